// File: rtl/adc_sequencer.sv
// adc_sequencer: periodic AD7983 trigger sequencer with power-of-two sample averaging,
// conversion timeout and sticky overrun/missed/timeout flags.
module adc_sequencer #(
  parameter int TIMEOUT    = 64,
  parameter int MIN_PERIOD = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  input  logic [2:0]  i_avg_log2,
  input  logic        i_clear_flags,
  output logic        o_adc_start,
  input  logic        i_adc_rdy,
  input  logic [15:0] i_adc_sample,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_data,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_missed,
  output logic        o_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_cnt, r_timer, r_out_data, w_eff;
  logic [19:0] r_acc, w_acc_sum;
  logic [4:0]  r_num, w_num_inc;
  logic [2:0]  r_lat;
  logic        r_rdy_q, r_out_valid, r_overrun, r_missed, r_timeout;
  logic        w_tick, w_edge, w_done, w_abort, w_load, w_flush;
  assign w_eff     = (i_period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : i_period;
  assign w_tick    = i_enable && (r_cnt == 16'd0);
  assign w_edge    = i_adc_rdy && !r_rdy_q;
  assign w_acc_sum = r_acc + {4'd0, i_adc_sample};
  assign w_num_inc = r_num + 5'd1;
  assign w_done    = (r_state == S_WAIT) && w_edge;
  // A sample edge arriving in the last timer cycle still counts; the abort only fires without one.
  assign w_abort   = (r_state == S_WAIT) && !w_edge && (r_timer == 16'(TIMEOUT - 1));
  assign w_load    = w_done && (w_num_inc == (5'd1 << r_lat));
  assign w_flush   = w_load || w_abort || ((r_state == S_IDLE) && !i_enable);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_tick ? S_TRIG : S_IDLE) :
             (r_state == S_TRIG) ? S_WAIT :
             (w_done || w_abort) ? S_IDLE : S_WAIT;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_acc       <= '0;
      r_num       <= '0;
      r_lat       <= '0;
      r_rdy_q     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_missed    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy_q <= i_adc_rdy;
      r_cnt   <= !i_enable ? 16'd0 : w_tick ? w_eff - 16'd1 : r_cnt - 16'd1;
      if (r_state == S_TRIG) begin
        r_timer <= '0;
        if (r_num == 5'd0) r_lat <= (i_avg_log2 > 3'd4) ? 3'd4 : i_avg_log2;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + 16'd1;
      end
      if (w_flush) begin
        r_acc <= '0;
        r_num <= '0;
      end else if (w_done) begin
        r_acc <= w_acc_sum;
        r_num <= w_num_inc;
      end
      if (w_load) r_out_data <= 16'(w_acc_sum >> r_lat);
      r_out_valid <= w_load || (r_out_valid && !i_out_ready);
      r_overrun   <= (w_load && r_out_valid && !i_out_ready) || (r_overrun && !i_clear_flags);
      r_missed    <= (w_tick && (r_state != S_IDLE)) || (r_missed && !i_clear_flags);
      r_timeout   <= w_abort || (r_timeout && !i_clear_flags);
    end
  end
  assign o_adc_start = (r_state == S_TRIG);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_overrun   = r_overrun;
  assign o_missed    = r_missed;
  assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: scoreboard bench; a reader model answers conversion requests and a
// transaction-level averaging model predicts every result the DUT must present.
module tb_adc_sequencer;
  localparam int TIMEOUT    = 64;
  localparam int MIN_PERIOD = 32;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear_flags = 1'b0;
  logic        adc_rdy = 1'b0, out_ready = 1'b1;
  logic [15:0] period = 16'd100, adc_sample = 16'd0;
  logic [2:0]  avg_log2 = 3'd0;
  logic        adc_start, out_valid, busy, overrun, missed, timeout;
  logic [15:0] out_data;

  adc_sequencer #(.TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_period(period),
    .i_avg_log2(avg_log2), .i_clear_flags(clear_flags), .o_adc_start(adc_start),
    .i_adc_rdy(adc_rdy), .i_adc_sample(adc_sample), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_busy(busy),
    .o_overrun(overrun), .o_missed(missed), .o_timeout(timeout)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Averaging model: groups of 2^min(avg_log2,4) delivered samples, reset by timeouts.
  int unsigned m_sum;
  int m_cnt = 0, m_lat = 0;
  int exp_q[$];
  function automatic void m_reset();
    m_sum = 0;
    m_cnt = 0;
  endfunction
  function automatic void m_start();
    if (m_cnt == 0) m_lat = (avg_log2 > 3'd4) ? 4 : int'(avg_log2);
  endfunction
  function automatic void m_deliver(int s);
    m_sum += s;
    m_cnt++;
    if (m_cnt == (1 << m_lat)) begin
      exp_q.push_back(int'((m_sum >> m_lat) & 32'hFFFF));
      m_reset();
    end
  endfunction

  // Reader model
  int  cfg_lat = 0, st_cnt = 0, pend = 0, hold = 0;
  bit  no_reply = 0, rnd_drop = 0, rnd_ready = 0;
  int  samp_q[$];
  int  st_cyc[$];
  initial forever begin
    @(negedge clk); #1;
    if (!rst_n) begin
      adc_rdy = 1'b0; pend = 0; hold = 0;
    end else if (adc_start) begin
      st_cnt++;
      st_cyc.push_back(cyc);
      m_start();
      adc_rdy = 1'b0;
      hold = 0;
      if (no_reply || (rnd_drop && $urandom_range(0, 7) == 0)) begin
        pend = 0;
        m_reset();
      end else pend = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 50));
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        adc_sample = (samp_q.size() != 0) ? 16'(samp_q.pop_front()) : 16'($urandom);
        adc_rdy = 1'b1;
        hold = $urandom_range(1, 3);
        m_deliver(int'(adc_sample));
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) adc_rdy = 1'b0;
    end
  end

  // Monitor: every accepted result must match the next prediction.
  int mon_pops = 0;
  initial forever begin
    @(negedge clk); #1;
    if (rst_n && out_valid && out_ready) begin
      mon_pops++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
      end else check("result", int'(out_data), exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_starts(int n, int bound);
    int tgt = st_cnt + n;
    int k = 0;
    while (st_cnt < tgt && k < bound) begin @(negedge clk); k++; end
    check("start_count", int'(st_cnt >= tgt), 1);
  endtask
  task automatic go_idle();
    int k = 0;
    enable = 1'b0;
    while ((busy || exp_q.size() != 0) && k < 300) begin @(negedge clk); k++; end
    check("go_idle", int'(busy || exp_q.size() != 0), 0);
    tick(2);
    m_reset();
  endtask
  task automatic pulse_clear();
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
  endtask
  task automatic check_all_zero(string tag);
    check({tag, "_adc_start"}, int'(adc_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_missed"}, int'(missed), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int en_c, s, k, p0, b;
    #1 check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    tick(2);
    // Periodic single-sample results, starts at cycles 1, 101, 201
    period = 16'd100; avg_log2 = 3'd0; cfg_lat = 20;
    samp_q = '{16'h1234, 16'h1234, 16'h1234};
    b = st_cyc.size();
    enable = 1'b1; en_c = cyc;
    wait_starts(3, 400);
    tick(30);
    check("start0_cycle", st_cyc[b] - en_c, 1);
    check("start1_cycle", st_cyc[b+1] - en_c, 101);
    check("start2_cycle", st_cyc[b+2] - en_c, 201);
    check("periodic_flags", int'({overrun, missed, timeout}), 0);
    go_idle();
    // Averaging of four samples, then a fresh group
    avg_log2 = 3'd2; cfg_lat = 15;
    samp_q = '{10, 20, 30, 41, 4, 4, 4, 8};
    enable = 1'b1;
    wait_starts(4, 500); tick(30);
    check("avg4_first", int'(out_data), 25);
    wait_starts(4, 500); tick(30);
    check("avg4_second", int'(out_data), 5);
    go_idle();
    // Reader never answers
    avg_log2 = 3'd0; period = 16'd100; no_reply = 1;
    enable = 1'b1;
    wait_starts(1, 10);
    s = st_cyc[$];
    k = 0;
    while (!timeout && k < 200) begin @(negedge clk); k++; end
    check("timeout_delay", int'((cyc - s) >= TIMEOUT && (cyc - s) <= TIMEOUT + 1), 1);
    check("timeout_idle", int'(busy), 0);
    wait_starts(1, 150);
    pulse_clear();
    check("timeout_cleared", int'(timeout), 0);
    no_reply = 0;
    go_idle();
    // Backpressure overwrite
    out_ready = 1'b0; cfg_lat = 10; period = 16'd50;
    samp_q = '{16'h0100, 16'h0200};
    enable = 1'b1;
    wait_starts(2, 200); tick(20);
    enable = 1'b0;
    check("overrun_set", int'(overrun), 1);
    check("overrun_data", int'(out_data), 16'h0200);
    check("overrun_valid", int'(out_valid), 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); #1;
    check("valid_after_accept", int'(out_valid), 0);
    pulse_clear();
    check("overrun_cleared", int'(overrun), 0);
    go_idle();
    // Short period clamps to MIN_PERIOD, long latency misses ticks, avg 7 acts as 16
    pulse_clear();
    period = 16'd5; cfg_lat = 40; avg_log2 = 3'd7;
    b = st_cyc.size(); p0 = mon_pops;
    enable = 1'b1;
    wait_starts(17, 1300); tick(50);
    check("missed_set", int'(missed), 1);
    check("start_spacing_a", st_cyc[b+1] - st_cyc[b], 2 * MIN_PERIOD);
    check("start_spacing_b", st_cyc[b+16] - st_cyc[b+15], 2 * MIN_PERIOD);
    check("avg16_results", mon_pops - p0, 1);
    go_idle();
    pulse_clear();
    // Reset in the middle of a partially accumulated group
    avg_log2 = 3'd2; cfg_lat = 20; period = 16'd40;
    enable = 1'b1;
    wait_starts(3, 300); tick(5);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete(); m_reset();
    tick(3);
    samp_q = '{100, 200, 300, 400};
    rst_n = 1'b1;
    wait_starts(4, 300); tick(30);
    check("fresh_after_reset", int'(out_data), 250);
    go_idle();
    // Randomized segments
    rnd_ready = 1; rnd_drop = 1; cfg_lat = 0;
    for (int i = 0; i < 6; i++) begin
      period = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(32, 90));
      avg_log2 = 3'($urandom_range(0, 7));
      pulse_clear();
      enable = 1'b1;
      tick(1500);
      go_idle();
    end
    rnd_ready = 0; out_ready = 1'b1;
    check("random_no_overrun", int'(overrun), 0);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: clocks allowed from adc_start to adc_rdy before abort.
REQ-002 Parameter MIN_PERIOD, default 32: smallest effective trigger period in clocks.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high: periodic sampling runs; low: no new triggers.
REQ-006 period  input  16  clocks between triggers; values below MIN_PERIOD behave as MIN_PERIOD.
REQ-007 avg_log2  input  3  samples per result = 2^avg_log2; values above 4 behave as 4.
REQ-008 clear_flags  input  1  one-cycle pulse that clears the sticky flags.
REQ-009 adc_start  output  1  one-cycle conversion request to the AD7983 reader.
REQ-010 adc_rdy  input  1  reader sample-valid level, high for at least 1 clock per sample.
REQ-011 adc_sample  input  16  reader sample word, valid while adc_rdy is high.
REQ-012 out_valid  output  1  averaged result available.
REQ-013 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-014 out_data  output  16  averaged result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 overrun  output  1  sticky: an unaccepted result was overwritten.
REQ-017 missed  output  1  sticky: a trigger tick occurred while not in IDLE.
REQ-018 timeout  output  1  sticky: a conversion was aborted after TIMEOUT clocks.

Function
REQ-019 Period counter SHALL hold 0 while enable is low.
REQ-020 Tick definition: tick = enable AND counter==0.
REQ-021 On tick, the counter SHALL reload max(period,MIN_PERIOD)-1; otherwise it SHALL decrement, so ticks are spaced exactly by the effective period.
REQ-022 The first tick SHALL occur in the first cycle enable is high.
REQ-023 States: IDLE, TRIG, WAIT.
REQ-024 IDLE->TRIG on tick.
REQ-025 TRIG SHALL drive adc_start=1 for exactly one cycle, clear the timeout timer, then go to WAIT.
REQ-026 In TRIG with sample count 0, avg_log2 SHALL be latched for the whole averaging group.
REQ-027 adc_start SHALL be high in the cycle after the tick, so latency from tick to start is 1 clock.
REQ-028 WAIT SHALL detect the adc_rdy rising edge against a registered copy of adc_rdy reset to 0; a level held for several cycles SHALL count once.
REQ-029 On that edge: accumulator (20 bit, unsigned) += adc_sample; sample count += 1; return to IDLE.
REQ-030 When the updated count equals 2^latched avg_log2, out_data SHALL be loaded with accumulator>>avg_log2 (truncated), out_valid set, and accumulator and count cleared in the same cycle.
REQ-031 WAIT timer increments each cycle; on reaching TIMEOUT: set timeout, clear accumulator and count, return to IDLE; no result is produced.
REQ-032 A tick in any state other than IDLE SHALL set missed and SHALL be dropped, not queued.
REQ-033 out_valid SHALL clear on out_valid AND out_ready unless a new result loads in the same cycle; a new result SHALL win and keep out_valid high.
REQ-034 If a result loads while out_valid is high and out_ready is low: overwrite out_data and set overrun.
REQ-035 Enable low mid-conversion: the current TRIG/WAIT SHALL complete normally; entering IDLE with enable low SHALL clear accumulator and count and SHALL NOT load a partial result.
REQ-036 If clear_flags and a flag-setting event occur in the same cycle, the flag SHALL end set.
REQ-037 period changes SHALL take effect only at the next reload.

Reset
REQ-038 Reset asserted (low) SHALL immediately force: state IDLE; adc_start, busy, out_valid, overrun, missed and timeout all 0; out_data 0; counter, timer, accumulator, count and the adc_rdy history all 0.
REQ-039 Reset asserted mid-conversion SHALL discard the in-flight sample and any result not yet accepted.
REQ-040 After reset deasserts, the first trigger SHALL follow REQ-022.

Verification
REQ-041 enable=1, period=100, avg_log2=0, reader model returns 0x1234 20 clocks after start -> adc_start at cycles 1,101,201; out_valid with 0x1234 after each sample; no flags.
REQ-042 avg_log2=2, samples 10,20,30,41 -> single result out_data=25 after the 4th sample; accumulator then restarts at 0.
REQ-043 Reader never asserts adc_rdy -> timeout set TIMEOUT clocks after adc_start, state back to IDLE, next tick retriggers; clear_flags then clears timeout.
REQ-044 out_ready held low across two results 0x0100 and 0x0200 -> overrun=1, out_data=0x0200; raising out_ready clears out_valid one cycle later.
REQ-045 period=5 (effective 32) with reader latency 40 -> missed=1, ticks spaced 32 clocks; avg_log2=7 behaves as 16 samples.
REQ-046 Reset asserted during WAIT with a partial accumulator -> all outputs 0 immediately; after release, the first result uses only fresh samples.
